// File: rtl/adex_update_scheduler.sv
// Time-multiplexed AdEx update sequencer: walks the neuron population through one
// shared datapath per tick, applying enable mask and refractory skipping.
module adex_update_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int REFRAC    = 2,
  localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  localparam int CW = $clog2(N_NEURONS + 1),
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_i,
  input  logic [N_NEURONS-1:0] en_mask_i,
  input  logic                 clr_ovr_i,
  output logic                 upd_valid_o,
  output logic [IW-1:0]        upd_idx_o,
  input  logic                 upd_ready_i,
  input  logic                 res_valid_i,
  input  logic                 res_spike_i,
  output logic [N_NEURONS-1:0] spike_vec_o,
  output logic [CW-1:0]        spike_cnt_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overrun_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_NEURONS - 1);

  state_t               state;
  logic [IW-1:0]        idx;
  logic [N_NEURONS-1:0] shadow;
  logic [RW-1:0]        refrac [N_NEURONS];

  logic                 adv;
  logic                 adv_bit;
  logic                 last;
  logic [IW-1:0]        nxt_idx;
  logic [N_NEURONS-1:0] nxt_shadow;

  function automatic logic [CW-1:0] popcount(input logic [N_NEURONS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_NEURONS; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // A neuron finishes either by being skipped in ISSUE or by its result arriving in WAIT.
  always_comb begin
    adv        = 1'b0;
    adv_bit    = 1'b0;
    nxt_shadow = shadow;
    case (state)
      ISSUE:   adv = !upd_valid_o;
      WAIT: begin
        adv     = res_valid_i;
        adv_bit = res_spike_i;
      end
      default: adv = 1'b0;
    endcase
    nxt_shadow[idx] = adv_bit;
    nxt_idx         = idx + IW'(1);
    last            = (idx == LAST_IDX);
  end

  // The request is decided on the edge entering ISSUE so upd_valid_o stays registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      shadow      <= '0;
      spike_vec_o <= '0;
      spike_cnt_o <= '0;
      upd_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) refrac[i] <= '0;
    end else begin
      if (tick_i && state != IDLE) overrun_o <= 1'b1;
      else if (clr_ovr_i)          overrun_o <= 1'b0;

      case (state)
        IDLE: begin
          if (tick_i) begin
            state       <= ISSUE;
            idx         <= '0;
            shadow      <= '0;
            upd_valid_o <= en_mask_i[0] && (refrac[0] == '0);
          end
        end
        ISSUE: begin
          if (upd_valid_o) begin
            if (upd_ready_i) begin
              upd_valid_o <= 1'b0;
              state       <= WAIT;
            end
          end else if (refrac[idx] != '0) begin
            refrac[idx] <= refrac[idx] - RW'(1);
          end
        end
        WAIT: begin
          if (res_valid_i && res_spike_i) refrac[idx] <= RW'(REFRAC);
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (adv) begin
        shadow <= nxt_shadow;
        if (last) begin
          state       <= DONE;
          spike_vec_o <= nxt_shadow;
          spike_cnt_o <= popcount(nxt_shadow);
        end else begin
          idx         <= nxt_idx;
          state       <= ISSUE;
          upd_valid_o <= en_mask_i[nxt_idx] && (refrac[nxt_idx] == '0);
        end
      end
    end
  end

  assign upd_idx_o = idx;
  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);

endmodule

// File: tb/tb_adex_update_scheduler.sv
// Directed bench for adex_update_scheduler: table of sweeps with a bench-side
// datapath responder, plus hand sequences for stray results and mid-sweep reset.
module tb_adex_update_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_i;
  logic [3:0] en_mask_i;
  logic       clr_ovr_i;
  logic       upd_valid_o;
  logic [1:0] upd_idx_o;
  logic       upd_ready_i;
  logic       res_valid_i;
  logic       res_spike_i;
  logic [3:0] spike_vec_o;
  logic [2:0] spike_cnt_o;
  logic       busy_o;
  logic       done_o;
  logic       overrun_o;

  int checks = 0;
  int errors = 0;

  adex_update_scheduler #(.N_NEURONS(4), .REFRAC(2)) dut (
    .clk(clk), .rst(rst), .tick_i(tick_i), .en_mask_i(en_mask_i),
    .clr_ovr_i(clr_ovr_i), .upd_valid_o(upd_valid_o), .upd_idx_o(upd_idx_o),
    .upd_ready_i(upd_ready_i), .res_valid_i(res_valid_i), .res_spike_i(res_spike_i),
    .spike_vec_o(spike_vec_o), .spike_cnt_o(spike_cnt_o), .busy_o(busy_o),
    .done_o(done_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  spikes;     // spike returned by the datapath for each neuron
    int          stall_idx;  // neuron whose request sees backpressure
    int          stall_n;
    int          tick_at;    // cycle of an extra tick (with clr) mid-sweep, 0 = none
    logic [15:0] exp_order;  // accepted indices as nibbles, 'F' fill
    int          exp_nreq;
    int          exp_done;   // cycles from tick to done_o
    int          exp_hold;
    logic [3:0]  exp_vec;
    int          exp_cnt;
    logic        exp_ovr;
  } vec_t;

  vec_t tbl [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_sweep(input vec_t v, input int row);
    logic [3:0]  prev_vec;
    logic [15:0] order;
    int nreq, done_cyc, busy_n, hold, stall_c, stable_bad, pidx;
    logic pend;
    prev_vec = spike_vec_o;
    order = 16'hFFFF;
    nreq = 0; done_cyc = -1; busy_n = 0; hold = 0; stall_c = 0; stable_bad = 0;
    pend = 1'b0; pidx = 0;
    en_mask_i   = v.mask;
    upd_ready_i = 1'b1;
    res_valid_i = 1'b0;
    res_spike_i = 1'b0;
    tick_i      = 1'b1;
    step();
    tick_i = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick_i      = (cyc == v.tick_at);
      clr_ovr_i   = (cyc == v.tick_at);
      res_valid_i = pend;
      res_spike_i = pend && v.spikes[pidx];
      pend        = 1'b0;
      if (busy_o) busy_n++;
      if (!done_o && spike_vec_o !== prev_vec) stable_bad++;
      if (upd_valid_o && int'(upd_idx_o) == v.stall_idx) hold++;
      if (upd_valid_o && int'(upd_idx_o) == v.stall_idx && stall_c < v.stall_n) begin
        upd_ready_i = 1'b0;
        stall_c++;
      end else begin
        upd_ready_i = 1'b1;
        if (upd_valid_o) begin
          order = {order[11:0], 2'b00, upd_idx_o};
          nreq++;
          pend = 1'b1;
          pidx = int'(upd_idx_o);
        end
      end
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      step();
    end
    tick_i = 1'b0; clr_ovr_i = 1'b0; res_valid_i = 1'b0; res_spike_i = 1'b0;
    chk($sformatf("r%0d_order", row), int'(order), int'(v.exp_order));
    chk($sformatf("r%0d_nreq", row), nreq, v.exp_nreq);
    chk($sformatf("r%0d_done_cyc", row), done_cyc, v.exp_done);
    chk($sformatf("r%0d_busy_cycles", row), busy_n, v.exp_done);
    chk($sformatf("r%0d_hold", row), hold, v.exp_hold);
    chk($sformatf("r%0d_vec_stable", row), stable_bad, 0);
    chk($sformatf("r%0d_vec", row), int'(spike_vec_o), int'(v.exp_vec));
    chk($sformatf("r%0d_cnt", row), int'(spike_cnt_o), v.exp_cnt);
    step();
    chk($sformatf("r%0d_done_pulse", row), int'(done_o), 0);
    chk($sformatf("r%0d_idle", row), int'(busy_o), 0);
    chk($sformatf("r%0d_overrun", row), int'(overrun_o), int'(v.exp_ovr));
    clr_ovr_i = 1'b1;
    step();
    clr_ovr_i = 1'b0;
    chk($sformatf("r%0d_overrun_clr", row), int'(overrun_o), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, int'(upd_valid_o), 0);
    chk({tag, "_idx"}, int'(upd_idx_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_vec"}, int'(spike_vec_o), 0);
    chk({tag, "_cnt"}, int'(spike_cnt_o), 0);
    chk({tag, "_ovr"}, int'(overrun_o), 0);
  endtask

  initial begin
    //        mask   spikes  stl stn tk  order     nrq done hold vec      cnt ovr
    tbl[0]  = '{4'hF, 4'b1010, -1, 0, 0, 16'h0123, 4, 9,  0, 4'b1010, 2, 1'b0};
    tbl[1]  = '{4'hF, 4'b0100, -1, 0, 3, 16'hFF02, 2, 7,  0, 4'b0100, 1, 1'b1};
    tbl[2]  = '{4'hF, 4'b0000, -1, 0, 0, 16'hFFF0, 1, 6,  0, 4'b0000, 0, 1'b0};
    tbl[3]  = '{4'hF, 4'b1001, -1, 0, 0, 16'hF013, 3, 8,  0, 4'b1001, 2, 1'b0};
    tbl[4]  = '{4'h0, 4'b1111, -1, 0, 0, 16'hFFFF, 0, 5,  0, 4'b0000, 0, 1'b0};
    tbl[5]  = '{4'h0, 4'b1111, -1, 0, 0, 16'hFFFF, 0, 5,  0, 4'b0000, 0, 1'b0};
    tbl[6]  = '{4'h5, 4'b1010, -1, 0, 0, 16'hFF02, 2, 7,  0, 4'b0000, 0, 1'b0};
    tbl[7]  = '{4'hF, 4'b0110,  2, 3, 0, 16'h0123, 4, 12, 4, 4'b0110, 2, 1'b0};
    tbl[8]  = '{4'h0, 4'b0000, -1, 0, 0, 16'hFFFF, 0, 5,  0, 4'b0000, 0, 1'b0};
    tbl[9]  = '{4'h9, 4'b1001, -1, 0, 0, 16'hFF03, 2, 7,  0, 4'b1001, 2, 1'b0};
    tbl[10] = '{4'hF, 4'b0011, -1, 0, 0, 16'h0123, 4, 9,  0, 4'b0011, 2, 1'b0};

    rst = 1'b1; tick_i = 1'b0; en_mask_i = 4'h0; clr_ovr_i = 1'b0;
    upd_ready_i = 1'b0; res_valid_i = 1'b0; res_spike_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_reset_vals("por");

    // Stray result and ready while idle
    res_valid_i = 1'b1; res_spike_i = 1'b1; upd_ready_i = 1'b1;
    step();
    res_valid_i = 1'b0; res_spike_i = 1'b0;
    step();
    chk("stray_busy", int'(busy_o), 0);
    chk("stray_valid", int'(upd_valid_o), 0);
    chk("stray_vec", int'(spike_vec_o), 0);

    for (int r = 0; r < 10; r++) run_sweep(tbl[r], r);

    // Mid-sweep reset while waiting on neuron 2 (neuron 0 is refractory here)
    en_mask_i = 4'hF; upd_ready_i = 1'b1; tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    chk("rs_skip0", int'(upd_valid_o), 0);
    step();
    chk("rs_req1", int'(upd_valid_o), 1);
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    res_valid_i = 1'b1; res_spike_i = 1'b1;
    step();
    res_valid_i = 1'b0; res_spike_i = 1'b0;
    chk("rs_req2", int'(upd_idx_o), 2);
    step();
    chk("rs_wait_valid", int'(upd_valid_o), 0);
    chk("rs_wait_idx", int'(upd_idx_o), 2);
    chk("rs_wait_busy", int'(busy_o), 1);
    chk("rs_wait_ovr", int'(overrun_o), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("rst");
    res_valid_i = 1'b1; res_spike_i = 1'b1;
    step();
    res_valid_i = 1'b0; res_spike_i = 1'b0;
    chk("late_busy", int'(busy_o), 0);
    chk("late_vec", int'(spike_vec_o), 0);
    chk("late_valid", int'(upd_valid_o), 0);
    run_sweep(tbl[10], 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
